// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack command sequencer.
// Optional feature macro: STACK_SEQ_SHADOW_CHECK_EN (see stack_alu_sequencer).
package stack_seq_pkg;

  localparam logic [2:0] STK_OP_NOP  = 3'b000;
  localparam logic [2:0] STK_OP_ADD  = 3'b100;
  localparam logic [2:0] STK_OP_MUL  = 3'b101;
  localparam logic [2:0] STK_OP_PUSH = 3'b110;
  localparam logic [2:0] STK_OP_POP  = 3'b111;

  localparam logic [1:0] CMD_PUSH = 2'b00;
  localparam logic [1:0] CMD_POP  = 2'b01;
  localparam logic [1:0] CMD_ADD  = 2'b10;
  localparam logic [1:0] CMD_MUL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } seq_state_e;

  function automatic logic [2:0] map_op(input logic [1:0] op);
    logic [2:0] r;
    r = STK_OP_NOP;
    unique case (op)
      CMD_PUSH: r = STK_OP_PUSH;
      CMD_POP:  r = STK_OP_POP;
      CMD_ADD:  r = STK_OP_ADD;
      CMD_MUL:  r = STK_OP_MUL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Command/response valid-ready channels of the stack sequencer.
// Optional feature macro: STACK_SEQ_SHADOW_CHECK_EN (not used here).
interface stack_seq_if #(
  parameter int N = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_overflow;
  logic         rsp_error;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid, rsp_data,
    input  rsp_overflow, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid, rsp_data,
    output rsp_overflow, rsp_error
  );
endinterface

// File: rtl/stack_seq_depth_tracker.sv
// Saturating 0..MAX_SIZE occupancy counter shadowing the stack.
// Optional feature macro: STACK_SEQ_SHADOW_CHECK_EN (not used here).
module stack_seq_depth_tracker #(
  parameter  int MAX_SIZE = 1024,
  localparam int DW = $clog2(MAX_SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [DW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ge2_o
);

  logic [DW-1:0] count_q;
  logic [DW-1:0] count_d;

  assign full_o  = (count_q == DW'(MAX_SIZE));
  assign empty_o = (count_q == '0);
  assign ge2_o   = (count_q >= DW'(2));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o)
      count_d = count_q + DW'(1);
    else if (dec_i && !inc_i && !empty_o)
      count_d = count_q - DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/stack_alu_sequencer.sv
// Turns push/pop/add/mul commands into timed stack opcodes.
// Define STACK_SEQ_SHADOW_CHECK_EN to reject commands using the shadow depth.
module stack_alu_sequencer
  import stack_seq_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_SIZE = 1024,
  localparam int DW       = $clog2(MAX_SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  stack_seq_if.slave    bus,
  output logic [2:0]    stk_opcode,
  output logic [N-1:0]  stk_input_data,
  input  logic [N-1:0]  stk_output_data,
  input  logic          stk_overflow,
  input  logic          stk_success,
  output logic [DW-1:0] depth
);

  seq_state_e   state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [N-1:0] data_q, data_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         rovf_q, rovf_d;
  logic         rerr_q, rerr_d;
  logic         inc, dec;
  logic         full, empty, ge2;
  logic         reject;
  logic         cmd_ready, rsp_valid;

  stack_seq_depth_tracker #(
    .MAX_SIZE(MAX_SIZE)
  ) u_depth (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (inc),
    .dec_i   (dec),
    .count_o (depth),
    .full_o  (full),
    .empty_o (empty),
    .ge2_o   (ge2)
  );

`ifdef STACK_SEQ_SHADOW_CHECK_EN
  always_comb begin
    reject = 1'b0;
    unique case (1'b1)
      (bus.cmd_op == CMD_PUSH): reject = full;
      (bus.cmd_op == CMD_POP):  reject = empty;
      default:                  reject = !ge2;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = full ^ empty ^ ge2;
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    data_d         = data_q;
    rdata_d        = rdata_q;
    rovf_d         = rovf_q;
    rerr_d         = rerr_q;
    inc            = 1'b0;
    dec            = 1'b0;
    stk_opcode     = STK_OP_NOP;
    stk_input_data = '0;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          if (reject) begin
            rdata_d = '0;
            rovf_d  = 1'b0;
            rerr_d  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        stk_opcode = map_op(op_q);
        if (op_q == CMD_PUSH)
          stk_input_data = data_q;
        state_d = WAIT;
      end
      WAIT: begin
        // stack outputs registered at end of ISSUE are stable here
        rdata_d = (op_q == CMD_PUSH) ? data_q
                                     : stk_output_data;
        rovf_d  = op_q[1] & stk_overflow;
        rerr_d  = !stk_success;
        inc     = stk_success && (op_q == CMD_PUSH);
        dec     = stk_success && (op_q == CMD_POP);
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= CMD_PUSH;
      data_q  <= '0;
      rdata_q <= '0;
      rovf_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      rovf_q  <= rovf_d;
      rerr_q  <= rerr_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_data     = rdata_q;
  assign bus.rsp_overflow = rovf_q;
  assign bus.rsp_error    = rerr_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Scoreboard bench for stack_alu_sequencer with a behavioural stack.
// Expectations follow STACK_SEQ_SHADOW_CHECK_EN when it is defined.
module tb_stack_alu_sequencer;

  localparam int N  = 4;
  localparam int MS = 4;
`ifdef STACK_SEQ_SHADOW_CHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_seq_if #(.N(N)) bus ();

  logic [2:0]   stk_opcode;
  logic [N-1:0] stk_input_data;
  logic [N-1:0] stk_output_data;
  logic         stk_overflow;
  logic         stk_success;
  logic [2:0]   depth;

  stack_alu_sequencer #(.N(N), .MAX_SIZE(MS)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .stk_opcode      (stk_opcode),
    .stk_input_data  (stk_input_data),
    .stk_output_data (stk_output_data),
    .stk_overflow    (stk_overflow),
    .stk_success     (stk_success),
    .depth           (depth)
  );

  // behavioural stack: registered outputs, held on nop
  logic signed [N-1:0] mem [MS];
  int sp;
  int top_v, nxt_v, sum_v, prd_v;

  always_comb begin
    top_v = (sp >= 1) ? int'(mem[(sp >= 1) ? sp - 1 : 0]) : 0;
    nxt_v = (sp >= 2) ? int'(mem[(sp >= 2) ? sp - 2 : 0]) : 0;
    sum_v = top_v + nxt_v;
    prd_v = top_v * nxt_v;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= 0;
      stk_output_data <= '0;
      stk_overflow <= 1'b0;
      stk_success <= 1'b0;
    end else begin
      case (stk_opcode)
        3'b110: begin
          stk_overflow <= 1'b0;
          if (sp < MS) begin
            mem[sp] <= stk_input_data;
            sp <= sp + 1;
            stk_output_data <= stk_input_data;
            stk_success <= 1'b1;
          end else begin
            stk_output_data <= '0;
            stk_success <= 1'b0;
          end
        end
        3'b111: begin
          stk_overflow <= 1'b0;
          if (sp > 0) begin
            stk_output_data <= top_v[N-1:0];
            sp <= sp - 1;
            stk_success <= 1'b1;
          end else begin
            stk_output_data <= '0;
            stk_success <= 1'b0;
          end
        end
        3'b100, 3'b101: begin
          if (sp >= 2) begin
            if (stk_opcode == 3'b100) begin
              stk_output_data <= sum_v[N-1:0];
              stk_overflow <= (sum_v > 7) || (sum_v < -8);
            end else begin
              stk_output_data <= prd_v[N-1:0];
              stk_overflow <= (prd_v > 7) || (prd_v < -8);
            end
            stk_success <= 1'b1;
          end else begin
            stk_output_data <= '0;
            stk_overflow <= 1'b0;
            stk_success <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [N-1:0] d;
    logic         o;
    logic         e;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: compare each response on the cycle it is taken
  always @(negedge clk) begin
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("rsp_data", 32'(bus.rsp_data), 32'(x.d));
        chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(x.o));
        chk("rsp_error", 32'(bus.rsp_error), 32'(x.e));
      end
    end
  end

  task automatic run(input string nm, input logic [1:0] op,
                     input logic [3:0] d, input logic [3:0] ed,
                     input logic eo, input logic ee,
                     input int elat, input logic [2:0] eopc,
                     input logic [2:0] edep, input int stall);
    bit ok;
    int lat;
    int nz;
    logic [2:0] opc;
    exp_t x;
    x.d = ed;
    x.o = eo;
    x.e = ee;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (stall > 0) bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_data = d;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_accept"}, 32'(ok), 32'd1);
    if (!ok) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    ok = 1'b0;
    lat = 0;
    nz = 0;
    opc = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (stk_opcode != 3'b000) begin
        nz++;
        opc = stk_opcode;
      end
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_rsp_seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_issue_cnt"}, 32'(nz), (eopc != 3'b000) ? 32'd1 : 32'd0);
    chk({nm, "_opcode"}, 32'(opc), 32'(eopc));
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_stall_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({nm, "_stall_ready"}, 32'(bus.cmd_ready), 32'd0);
        chk({nm, "_stall_data"}, 32'(bus.rsp_data), 32'(ed));
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk({nm, "_depth"}, 32'(depth), 32'(edep));
  endtask

  initial begin
    int cnt;
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_data = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_error), 32'd0);
    chk("rst_opcode", 32'(stk_opcode), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run("pop_empty", 2'b01, 4'h0, 4'h0, 1'b0, 1'b1,
        SC ? 1 : 3, SC ? 3'b000 : 3'b111, 3'd0, 0);

    run("push3", 2'b00, 4'h3, 4'h3, 1'b0, 1'b0, 3, 3'b110, 3'd1, 0);
    run("pushm2", 2'b00, 4'hE, 4'hE, 1'b0, 1'b0, 3, 3'b110, 3'd2, 0);
    run("add1", 2'b10, 4'h0, 4'h1, 1'b0, 1'b0, 3, 3'b100, 3'd2, 0);
    run("pop_m2", 2'b01, 4'h0, 4'hE, 1'b0, 1'b0, 3, 3'b111, 3'd1, 0);
    run("pop_3", 2'b01, 4'h0, 4'h3, 1'b0, 1'b0, 3, 3'b111, 3'd0, 0);

    run("push7", 2'b00, 4'h7, 4'h7, 1'b0, 1'b0, 3, 3'b110, 3'd1, 0);
    run("push5", 2'b00, 4'h5, 4'h5, 1'b0, 1'b0, 3, 3'b110, 3'd2, 0);
    run("add_ovf", 2'b10, 4'h0, 4'hC, 1'b1, 1'b0, 3, 3'b100, 3'd2, 0);
    run("pop_5", 2'b01, 4'h0, 4'h5, 1'b0, 1'b0, 3, 3'b111, 3'd1, 0);
    run("pop_7", 2'b01, 4'h0, 4'h7, 1'b0, 1'b0, 3, 3'b111, 3'd0, 0);

    run("push3b", 2'b00, 4'h3, 4'h3, 1'b0, 1'b0, 3, 3'b110, 3'd1, 0);
    run("pushm3", 2'b00, 4'hD, 4'hD, 1'b0, 1'b0, 3, 3'b110, 3'd2, 0);
    run("mul_ovf", 2'b11, 4'h0, 4'h7, 1'b1, 1'b0, 3, 3'b101, 3'd2, 0);
    run("pop_m3", 2'b01, 4'h0, 4'hD, 1'b0, 1'b0, 3, 3'b111, 3'd1, 0);
    run("pop_3b", 2'b01, 4'h0, 4'h3, 1'b0, 1'b0, 3, 3'b111, 3'd0, 0);

    run("add_empty", 2'b10, 4'h0, 4'h0, 1'b0, 1'b1,
        SC ? 1 : 3, SC ? 3'b000 : 3'b100, 3'd0, 0);

    run("fill1", 2'b00, 4'h1, 4'h1, 1'b0, 1'b0, 3, 3'b110, 3'd1, 0);
    run("fill2", 2'b00, 4'h2, 4'h2, 1'b0, 1'b0, 3, 3'b110, 3'd2, 0);
    run("fill3", 2'b00, 4'h3, 4'h3, 1'b0, 1'b0, 3, 3'b110, 3'd3, 0);
    run("fill4", 2'b00, 4'h4, 4'h4, 1'b0, 1'b0, 3, 3'b110, 3'd4, 0);
    run("push_full", 2'b00, 4'h5, SC ? 4'h0 : 4'h5, 1'b0, 1'b1,
        SC ? 1 : 3, SC ? 3'b000 : 3'b110, 3'd4, 0);

    run("pop_stall", 2'b01, 4'h0, 4'h4, 1'b0, 1'b0, 3, 3'b111, 3'd3, 5);

    // reset while the next command sits in WAIT
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b00;
    bus.cmd_data = 4'h9;
    cnt = 0;
    while (!bus.cmd_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wait_opcode", 32'(stk_opcode), 32'd0);
    chk("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("mid_rst_rsp_ovf", 32'(bus.rsp_overflow), 32'd0);
    chk("mid_rst_rsp_err", 32'(bus.rsp_error), 32'd0);
    chk("mid_rst_opcode", 32'(stk_opcode), 32'd0);
    chk("mid_rst_in_data", 32'(stk_input_data), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    chk("no_rsp_after_rst", 32'(cnt), 32'd0);

    run("push6_after_rst", 2'b00, 4'h6, 4'h6, 1'b0, 1'b0,
        3, 3'b110, 3'd1, 0);

    repeat (2) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stack_alu_sequencer.md
# stack_alu_sequencer

Command-side front end for the ALU-based stack. Accepts high-level stack commands (push, pop, add, mul) over a valid/ready channel and drives the stack's opcode/data port with correctly timed single-cycle operations. Captures the stack's result, overflow and success flags and returns them over a valid/ready response channel. Keeps a shadow depth count so callers never have to track stack occupancy themselves.

## Interface
- N, 4, data width (matches the stack's N)
- MAX_SIZE, 1024, stack capacity (matches the stack's MAX_SIZE)
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; the attached stack shares this reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_op  in  2  00 push, 01 pop, 10 add, 11 mul
- cmd_data  in  N  push operand (signed); ignored for other ops
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_data  out  N  signed result
- rsp_overflow  out  1  arithmetic overflow of add/mul
- rsp_error  out  1  command failed (rejected locally, or the stack reported no success)
- stk_opcode  out  3  to stack: 000 nop, 100 add, 101 mul, 110 push, 111 pop
- stk_input_data  out  N  to stack input_data
- stk_output_data  in  N  from stack output_data
- stk_overflow  in  1  from stack overflow
- stk_success  in  1  from stack success
- depth  out  $clog2(MAX_SIZE+1)  shadow occupancy

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_op/cmd_data and go to ISSUE, or go to RESP directly if the command is rejected (see Configuration).
- ISSUE: stk_opcode = mapped op; stk_input_data = latched data for push, 0 otherwise. Lasts exactly one cycle. Next state is WAIT.
- WAIT: stk_opcode = 000. At the end of WAIT, capture stk_output_data, stk_overflow and stk_success, then go to RESP.
- RESP: rsp_valid=1, and the response is held stable. When rsp_ready=1, go to IDLE.
- rsp_data: push returns the pushed value; pop/add/mul return the captured stk_output_data.
- rsp_overflow: the captured stk_overflow for add/mul; forced to 0 for push/pop.
- rsp_error = !stk_success for issued commands.
- Add and mul read the top two entries without consuming them, so depth is unchanged.
- Depth update at the end of WAIT, only when stk_success=1: push +1, pop -1.
- Outside ISSUE, stk_opcode = 000 and the stack holds its state.

## Timing
- Reset values: state IDLE; cmd_ready=1; rsp_valid, rsp_data, rsp_overflow, rsp_error = 0; stk_opcode=000; stk_input_data=0; depth=0.
- Accepted command at edge k: ISSUE in cycle k+1, WAIT in k+2, rsp_valid from k+3.
- A rejected command is accepted at edge k and has rsp_valid from k+1; no stack opcode is issued.
- Throughput: at most one command per 4 cycles (2 if rejected), plus any rsp_ready stall.
- cmd_ready=0 from acceptance until the RESP handshake completes; no command queueing.
- Reset asserted mid-operation (any state): all outputs return to reset values immediately. The in-flight command is dropped with no response.
- Arithmetic is two's complement; results are truncated to N bits by the stack, and the sequencer does not widen them.

## Configuration
- STACK_SEQ_SHADOW_CHECK_EN defined: commands are checked in IDLE against depth. Rejected cases:
  - pop with depth==0
  - add/mul with depth<2
  - push with depth==MAX_SIZE
  - A rejected command gives rsp_error=1, rsp_data=0, rsp_overflow=0, and no stack access.
- STACK_SEQ_SHADOW_CHECK_EN undefined: every command is issued. Errors come only from stk_success. Depth is still tracked.

## Structure
- Package stack_seq_pkg holds:
  - stack opcode constants STK_OP_NOP/ADD/MUL/PUSH/POP
  - cmd_op encodings CMD_PUSH/POP/ADD/MUL
  - the FSM state enum
- One sub-module, stack_seq_depth_tracker: a saturating up/down counter in the range 0..MAX_SIZE, with inc/dec inputs and full/empty/ge2 flags.

## Test plan
- N=4: push 3, push -2, add -> rsp_data=1, rsp_overflow=0, depth=2; rsp_valid exactly 3 cycles after acceptance.
- Push 7, push 5, add -> rsp_data=-4, rsp_overflow=1. Then pop -> rsp_data=5, pop -> rsp_data=7, depth=0.
- Push 3, push -3, mul -> rsp_data=7 (-9 truncated), rsp_overflow=1.
- Empty stack, pop:
  - with the macro: rsp_error=1 one cycle after acceptance, and stk_opcode never leaves 000;
  - without the macro: pop is issued, stk_success=0 gives rsp_error=1, and depth stays 0.
- MAX_SIZE=4: 4 pushes succeed, the 5th returns rsp_error=1, and depth stays 4.
- Hold rsp_ready=0 for 5 cycles: response stable, cmd_ready=0. Then drop rst during WAIT of the next command -> outputs return to reset values immediately, and no response appears.
